he_vec_accel: RTL and testbench

- Parametrised successor to the single-lane HE accelerator.
- Executes issue-queue commands (iq_assert/funct3/source/destination) on an internal scratchpad of NUM_REGS polynomials, N coefficients each, processing LANES coefficients per beat.
- Supports runtime plaintext modulus t and ciphertext modulus q (SETPARAM), elementwise modular ADD/SUB/NEG/COPY, and a multi-cycle SCALE-by-t.
- A host port loads and reads polynomials while the block is idle.

---
 rtl/he_vec_accel.sv | 198 +++++++++++++++++++
 tb/tb_he_vec_accel.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/he_vec_accel.sv
// rtl/he_vec_accel.sv - multi-lane modular vector accelerator over a polynomial scratchpad
// Executes ADD/SUB/NEG/COPY one beat per cycle and SCALE-by-t as bit-serial double-and-add.
module he_vec_accel #(
    parameter int BIT_WIDTH = 32,
    parameter int LANES     = 4,
    parameter int N         = 16,
    parameter int NUM_REGS  = 4,
    localparam int RW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int BEATS    = N / LANES,
    localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int DW       = LANES * BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iq_assert,
    input  logic [2:0]           funct3,
    input  logic [2*RW-1:0]      source,
    input  logic [RW-1:0]        destination,
    input  logic [BIT_WIDTH-1:0] param_data,
    output logic                 accel_ready,
    output logic                 accel_done,
    output logic                 accel_err,
    input  logic                 ext_en,
    input  logic                 ext_we,
    input  logic [RW-1:0]        ext_reg,
    input  logic [BW-1:0]        ext_idx,
    input  logic [DW-1:0]        ext_wdata,
    output logic [DW-1:0]        ext_rdata
);

    localparam int CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NEG   = 3'b010;
    localparam logic [2:0] OP_COPY  = 3'b011;
    localparam logic [2:0] OP_SCALE = 3'b100;
    localparam logic [2:0] OP_SETP  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MULT, S_DONE} state_t;

    state_t               state, state_nx;
    logic [2:0]           op_r;
    logic [RW-1:0]        src1_r, src2_r, dst_r;
    logic                 err_r;
    logic [BIT_WIDTH-1:0] t_r, q_r, t_sh;
    logic [BW-1:0]        beat;
    logic [CW-1:0]        bit_cnt;
    logic [DW-1:0]        acc_r, acc_nx, res_word, a_word, b_word;
    logic [DW-1:0]        mem [NUM_REGS][BEATS];

    logic accept, illegal, arith, cmd_err, last_beat, last_bit;

    function automatic logic [BIT_WIDTH-1:0] mod_add(input logic [BIT_WIDTH-1:0] x,
                                                      input logic [BIT_WIDTH-1:0] y,
                                                      input logic [BIT_WIDTH-1:0] m);
        logic [BIT_WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[BIT_WIDTH-1:0];
    endfunction

    // Wrapping arithmetic keeps x - y + m exact since the true result lies in [0, m).
    function automatic logic [BIT_WIDTH-1:0] mod_sub(input logic [BIT_WIDTH-1:0] x,
                                                      input logic [BIT_WIDTH-1:0] y,
                                                      input logic [BIT_WIDTH-1:0] m);
        return (x >= y) ? (x - y) : (x - y + m);
    endfunction

    assign accept    = iq_assert && (state == S_IDLE);
    assign illegal   = (funct3 == 3'b101) || (funct3 == 3'b110);
    assign arith     = (funct3 == OP_ADD) || (funct3 == OP_SUB) ||
                       (funct3 == OP_NEG) || (funct3 == OP_SCALE);
    assign cmd_err   = illegal || (arith && (q_r == '0));
    assign last_beat = (beat == BW'(BEATS - 1));
    assign last_bit  = (bit_cnt == CW'(BIT_WIDTH - 1));

    assign a_word = mem[src1_r][beat];
    assign b_word = mem[src2_r][beat];

    assign accel_ready = (state == S_IDLE);
    assign accel_done  = (state == S_DONE);
    assign accel_err   = (state == S_DONE) && err_r;

    always_comb begin
        logic [BIT_WIDTH-1:0] a, b, acc_l, dbl;
        res_word = '0;
        acc_nx   = '0;
        a        = '0;
        b        = '0;
        acc_l    = '0;
        dbl      = '0;
        for (int l = 0; l < LANES; l++) begin
            a = a_word[l*BIT_WIDTH +: BIT_WIDTH];
            b = b_word[l*BIT_WIDTH +: BIT_WIDTH];
            case (op_r)
                OP_ADD:  res_word[l*BIT_WIDTH +: BIT_WIDTH] = mod_add(a, b, q_r);
                OP_SUB:  res_word[l*BIT_WIDTH +: BIT_WIDTH] = mod_sub(a, b, q_r);
                OP_NEG:  res_word[l*BIT_WIDTH +: BIT_WIDTH] = (a == '0) ? '0 : (q_r - a);
                default: res_word[l*BIT_WIDTH +: BIT_WIDTH] = a;
            endcase
            // Accumulator starts from zero on the first bit of every beat.
            acc_l = (bit_cnt == '0) ? '0 : acc_r[l*BIT_WIDTH +: BIT_WIDTH];
            dbl   = mod_add(acc_l, acc_l, q_r);
            acc_nx[l*BIT_WIDTH +: BIT_WIDTH] = t_sh[BIT_WIDTH-1] ? mod_add(dbl, a, q_r) : dbl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_err || (funct3 == OP_SETP))
                        state_nx = S_DONE;
                    else if (funct3 == OP_SCALE)
                        state_nx = S_MULT;
                    else
                        state_nx = S_RUN;
                end
            end
            S_RUN:   if (last_beat) state_nx = S_DONE;
            S_MULT:  if (last_beat && last_bit) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem       <= '{default: '0};
            ext_rdata <= '0;
            t_r       <= '0;
            q_r       <= '0;
            t_sh      <= '0;
            op_r      <= '0;
            src1_r    <= '0;
            src2_r    <= '0;
            dst_r     <= '0;
            err_r     <= 1'b0;
            beat      <= '0;
            bit_cnt   <= '0;
            acc_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r    <= funct3;
                        src1_r  <= source[RW-1:0];
                        src2_r  <= source[2*RW-1:RW];
                        dst_r   <= destination;
                        err_r   <= cmd_err;
                        beat    <= '0;
                        bit_cnt <= '0;
                        t_sh    <= t_r;
                        if (funct3 == OP_SETP) begin
                            if (destination[0])
                                q_r <= param_data;
                            else
                                t_r <= param_data;
                        end
                    end else if (ext_en) begin
                        if (ext_we)
                            mem[ext_reg][ext_idx] <= ext_wdata;
                        else
                            ext_rdata <= mem[ext_reg][ext_idx];
                    end
                end
                S_RUN: begin
                    mem[dst_r][beat] <= res_word;
                    beat             <= beat + 1'b1;
                end
                S_MULT: begin
                    acc_r <= acc_nx;
                    if (last_bit) begin
                        mem[dst_r][beat] <= acc_nx;
                        beat             <= beat + 1'b1;
                        bit_cnt          <= '0;
                        t_sh             <= t_r;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        t_sh    <= {t_sh[BIT_WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_he_vec_accel.sv
// tb/tb_he_vec_accel.sv - directed self-checking bench for he_vec_accel
module tb_he_vec_accel;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          iq_assert;
    logic [2:0]    funct3;
    logic [3:0]    source;
    logic [1:0]    destination;
    logic [31:0]   param_data;
    logic          accel_ready, accel_done, accel_err;
    logic          ext_en, ext_we;
    logic [1:0]    ext_reg, ext_idx;
    logic [DW-1:0] ext_wdata, ext_rdata;

    int checks = 0;
    int errors = 0;

    he_vec_accel dut (
        .clk(clk), .reset(reset), .iq_assert(iq_assert), .funct3(funct3),
        .source(source), .destination(destination), .param_data(param_data),
        .accel_ready(accel_ready), .accel_done(accel_done), .accel_err(accel_err),
        .ext_en(ext_en), .ext_we(ext_we), .ext_reg(ext_reg), .ext_idx(ext_idx),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {a3[31:0], a2[31:0], a1[31:0], a0[31:0]};
    endfunction

    task automatic host_wr(input logic [1:0] r, input logic [1:0] i, input logic [DW-1:0] d);
        @(negedge clk);
        ext_en = 1'b1; ext_we = 1'b1; ext_reg = r; ext_idx = i; ext_wdata = d;
        @(negedge clk);
        ext_en = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] r, input logic [1:0] i, output logic [DW-1:0] d);
        @(negedge clk);
        ext_en = 1'b1; ext_we = 1'b0; ext_reg = r; ext_idx = i;
        @(negedge clk);
        ext_en = 1'b0;
        d = ext_rdata;
    endtask

    // Returns at the first negedge after the accept edge.
    task automatic start_cmd(input logic [2:0] f, input logic [1:0] s1, input logic [1:0] s2,
                             input logic [1:0] d, input logic [31:0] pd);
        @(negedge clk);
        iq_assert = 1'b1; funct3 = f; source = {s2, s1}; destination = d; param_data = pd;
        @(negedge clk);
        iq_assert = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat, output logic err);
        lat = c0;
        while (!accel_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        err = accel_err;
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] f, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] d, input logic [31:0] pd,
                           input int exp_lat, input logic exp_err);
        int lat;
        logic err;
        start_cmd(f, s1, s2, d, pd);
        wait_done(1, lat, err);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, err, exp_err);
        @(negedge clk);
        check({tag, "_ready_after"}, {accel_ready, accel_done}, 2'b10);
    endtask

    initial begin
        logic [DW-1:0] rd;
        int lat;
        logic err;
        logic seen_done;

        reset = 1'b1; iq_assert = 1'b0; funct3 = '0; source = '0; destination = '0;
        param_data = '0; ext_en = 1'b0; ext_we = 1'b0; ext_reg = '0; ext_idx = '0;
        ext_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", {accel_ready, accel_done, accel_err}, 3'b100);
        check("reset_rdata", ext_rdata, '0);

        run_cmd("setp_t", 3'b111, 2'd0, 2'd0, 2'd0, 32'd5, 1, 1'b0);
        run_cmd("setp_q", 3'b111, 2'd0, 2'd0, 2'd1, 32'd13, 1, 1'b0);

        host_wr(2'd0, 2'd0, pk(7, 12, 0, 5));
        host_wr(2'd1, 2'd0, pk(9, 1, 0, 8));
        run_cmd("add", 3'b000, 2'd0, 2'd1, 2'd2, 32'd0, 5, 1'b0);
        host_rd(2'd2, 2'd0, rd);
        check("add_b0", rd, pk(3, 0, 0, 0));
        host_rd(2'd2, 2'd1, rd);
        check("add_b1", rd, '0);

        run_cmd("sub", 3'b001, 2'd0, 2'd1, 2'd3, 32'd0, 5, 1'b0);
        host_rd(2'd3, 2'd0, rd);
        check("sub_b0", rd, pk(11, 11, 0, 10));

        // SCALE with a competing command, host write and host read while busy.
        start_cmd(3'b100, 2'd0, 2'd0, 2'd1, 32'd0);
        check("scale_busy", accel_ready, 1'b0);
        iq_assert = 1'b1; funct3 = 3'b000; source = {2'd0, 2'd0}; destination = 2'd3;
        ext_en = 1'b1; ext_we = 1'b1; ext_reg = 2'd1; ext_idx = 2'd1; ext_wdata = pk(1, 2, 3, 4);
        @(negedge clk);
        iq_assert = 1'b0; ext_we = 1'b0; ext_reg = 2'd0; ext_idx = 2'd0;
        @(negedge clk);
        ext_en = 1'b0;
        check("scale_rdata_held", ext_rdata, pk(11, 11, 0, 10));
        wait_done(3, lat, err);
        check("scale_lat", lat, 129);
        check("scale_err", err, 1'b0);
        @(negedge clk);
        check("scale_ready_after", {accel_ready, accel_done}, 2'b10);
        host_rd(2'd1, 2'd0, rd);
        check("scale_b0", rd, pk(9, 8, 0, 12));
        host_rd(2'd1, 2'd1, rd);
        check("scale_b1_no_host_wr", rd, '0);
        host_rd(2'd3, 2'd0, rd);
        check("scale_ignored_add", rd, pk(11, 11, 0, 10));

        run_cmd("neg", 3'b010, 2'd0, 2'd0, 2'd0, 32'd0, 5, 1'b0);
        host_rd(2'd0, 2'd0, rd);
        check("neg_b0", rd, pk(6, 1, 0, 8));

        run_cmd("illegal", 3'b110, 2'd0, 2'd0, 2'd0, 32'd0, 1, 1'b1);
        host_rd(2'd0, 2'd0, rd);
        check("illegal_nowrite", rd, pk(6, 1, 0, 8));

        // q==0 after reset: arithmetic rejected, COPY allowed.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        run_cmd("add_q0", 3'b000, 2'd0, 2'd1, 2'd2, 32'd0, 1, 1'b1);
        host_wr(2'd0, 2'd0, pk(1, 2, 3, 4));
        run_cmd("copy_q0", 3'b011, 2'd0, 2'd0, 2'd2, 32'd0, 5, 1'b0);
        host_rd(2'd2, 2'd0, rd);
        check("copy_b0", rd, pk(1, 2, 3, 4));

        // Reset two cycles into an ADD.
        run_cmd("setp_q2", 3'b111, 2'd0, 2'd0, 2'd1, 32'd13, 1, 1'b0);
        host_wr(2'd0, 2'd0, pk(7, 12, 0, 5));
        start_cmd(3'b000, 2'd0, 2'd0, 2'd2, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", {accel_ready, accel_done}, 2'b10);
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen_done = seen_done | accel_done;
        end
        check("abort_no_done", seen_done, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 4; b++) begin
                host_rd(r[1:0], b[1:0], rd);
                check($sformatf("abort_zero_r%0d_b%0d", r, b), rd, '0);
            end
        end

        // Command and host write in the same cycle: command wins.
        host_wr(2'd0, 2'd0, pk(4, 4, 4, 4));
        @(negedge clk);
        iq_assert = 1'b1; funct3 = 3'b011; source = {2'd0, 2'd0}; destination = 2'd1;
        ext_en = 1'b1; ext_we = 1'b1; ext_reg = 2'd0; ext_idx = 2'd0; ext_wdata = pk(9, 9, 9, 9);
        @(negedge clk);
        iq_assert = 1'b0; ext_en = 1'b0;
        wait_done(1, lat, err);
        check("collide_lat", lat, 5);
        host_rd(2'd1, 2'd0, rd);
        check("collide_copy", rd, pk(4, 4, 4, 4));
        host_rd(2'd0, 2'd0, rd);
        check("collide_wr_dropped", rd, pk(4, 4, 4, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
